// File: rtl/ocx_dlx_tx_gbx_param.sv
// DLX transmit gearbox: TX flit queue to 64b/66b PHY gearbox, 64- or 32-bit beats.
// Define OCX_DLX_TX_GBX_EDPL_EN to build the EDPL parity-in-header and inject logic.
module ocx_dlx_tx_gbx_param #(
    parameter int DATA_W = 64
) (
    input  logic              dlx_clk,
    input  logic              dlx_reset,
    input  logic              ctl_gb_train,
    input  logic              ctl_gb_tx_a_pattern,
    input  logic              ctl_gb_tx_b_pattern,
    input  logic              ctl_gb_tx_sync_pattern,
    input  logic              ctl_gb_tx_zeros,
    input  logic              orx_otx_train_failed,
    input  logic [DATA_W-1:0] que_gb_data,
    input  logic              que_gb_valid,
    output logic              que_gb_ready,
    input  logic              edpl_ena,
    input  logic              edpl_inj,
    output logic              qb_hwwe,
    output logic              gb_underrun,
    output logic [5:0]        dlx_phy_tx_seq,
    output logic [1:0]        dlx_phy_tx_header,
    output logic              dlx_phy_tx_hdr_valid,
    output logic [DATA_W-1:0] dlx_phy_tx_data
);
    localparam int BEATS = 64 / DATA_W;
    localparam logic [63:0] PAT_A    = 64'hFF00_FF00_FF00_FF00;
    localparam logic [63:0] PAT_B    = 64'hFF00_FF00_FFFF_0000;
    localparam logic [63:0] PAT_SYNC = 64'hFF00_FF00_FF00_00FF;

    typedef enum logic [1:0] {M_DATA = 2'd0, M_TRAIN = 2'd1, M_PAT = 2'd2, M_DIS = 2'd3} mode_e;

    logic              beat_q, beat_d;
    logic [5:0]        seq_q, seq_d;
    mode_e             mode_q, mode_d;
    logic [1:0]        hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [5:0]        seq_out_q, seq_out_d;
    logic              hv_q, hv_d;
    logic              uf_q, uf_d;

    logic              first_beat_s, last_beat_s, pause_s;
    mode_e             mode_in_s, mode_cur_s;
    logic [5:0]        rot_sh_s;
    logic [63:0]       pat_s, rot_s, pay_s;
    logic [DATA_W-1:0] pat_word_s, beat_data_s;

`ifdef OCX_DLX_TX_GBX_EDPL_EN
    logic par_q, par_d, t_q, t_d, inj_q, inj_d, inj_prev_q, hwwe_q, rise_s;
    assign rise_s = edpl_ena & edpl_inj & ~inj_prev_q;
    assign qb_hwwe = hwwe_q;
`else
    logic unused_edpl_s;
    assign unused_edpl_s = edpl_ena ^ edpl_inj;
    assign qb_hwwe = 1'b0;
`endif

    assign first_beat_s = ~beat_q;
    assign last_beat_s  = (BEATS == 1) ? 1'b1 : beat_q;
    assign pause_s      = (seq_q == 6'd32);

    // Requested mode by priority; only sampled on beat 0, then held for the block
    always_comb begin
        mode_in_s = M_DATA;
        if (ctl_gb_tx_zeros | orx_otx_train_failed) begin
            mode_in_s = M_DIS;
        end else if (ctl_gb_tx_a_pattern | ctl_gb_tx_b_pattern | ctl_gb_tx_sync_pattern) begin
            mode_in_s = M_PAT;
        end else if (ctl_gb_train) begin
            mode_in_s = M_TRAIN;
        end else begin
            mode_in_s = M_DATA;
        end
    end

    assign mode_cur_s   = first_beat_s ? mode_in_s : mode_q;
    assign que_gb_ready = ~dlx_reset & ~pause_s & ((mode_cur_s == M_DATA) | (mode_cur_s == M_TRAIN));

    // Training pattern rotated by two bits per block; the header takes the top two bits
    assign pat_s      = ctl_gb_tx_sync_pattern ? PAT_SYNC : (ctl_gb_tx_b_pattern ? PAT_B : PAT_A);
    assign rot_sh_s   = {seq_q[4:0], 1'b0};
    assign rot_s      = (pat_s << rot_sh_s) | (pat_s >> (7'd64 - {1'b0, rot_sh_s}));
    assign pay_s      = {rot_s[61:0], rot_s[63:62]};
    assign pat_word_s = first_beat_s ? pay_s[63 -: DATA_W] : pay_s[DATA_W-1:0];
    assign beat_data_s = que_gb_valid ? que_gb_data : {DATA_W{1'b0}};

    // Counters, per-beat output selection and EDPL header encoding
    always_comb begin
        beat_d    = (BEATS > 1) ? ~beat_q : 1'b0;
        seq_d     = seq_q;
        mode_d    = mode_cur_s;
        hdr_d     = hdr_q;
        data_d    = data_q;
        seq_out_d = seq_q;
        hv_d      = first_beat_s;
        uf_d      = 1'b0;
`ifdef OCX_DLX_TX_GBX_EDPL_EN
        par_d = par_q;
        t_d   = t_q;
        inj_d = inj_q | rise_s;
`endif
        if (last_beat_s) begin
            seq_d = pause_s ? 6'd0 : seq_q + 6'd1;
        end else begin
            seq_d = seq_q;
        end

        // The pause block leaves header, data and EDPL state untouched
        if (!pause_s) begin
            case (mode_cur_s)
                M_DIS: begin
                    data_d = {DATA_W{1'b0}};
                    hdr_d  = 2'b00;
`ifdef OCX_DLX_TX_GBX_EDPL_EN
                    par_d = 1'b0;
                    t_d   = 1'b0;
`endif
                end
                M_PAT: begin
                    data_d = pat_word_s;
                    if (first_beat_s) hdr_d = rot_s[63:62];
                    else              hdr_d = hdr_q;
`ifdef OCX_DLX_TX_GBX_EDPL_EN
                    par_d = 1'b0;
`endif
                end
                M_TRAIN: begin
                    data_d = beat_data_s;
                    uf_d   = ~que_gb_valid;
                    if (first_beat_s) hdr_d = 2'b10;
                    else              hdr_d = hdr_q;
`ifdef OCX_DLX_TX_GBX_EDPL_EN
                    par_d = 1'b0;
`endif
                end
                M_DATA: begin
                    data_d = beat_data_s;
                    uf_d   = ~que_gb_valid;
`ifdef OCX_DLX_TX_GBX_EDPL_EN
                    par_d = (first_beat_s ? 1'b0 : par_q) ^ (^beat_data_s);
                    if (first_beat_s && edpl_ena) begin
                        if (par_q ^ inj_q) begin
                            hdr_d = {t_q, t_q};
                            t_d   = ~t_q;
                        end else begin
                            hdr_d = 2'b01;
                        end
                        inj_d = rise_s;
                    end else if (first_beat_s) begin
                        hdr_d = 2'b01;
                    end else begin
                        hdr_d = hdr_q;
                    end
`else
                    if (first_beat_s) hdr_d = 2'b01;
                    else              hdr_d = hdr_q;
`endif
                end
                default: begin
                    data_d = {DATA_W{1'b0}};
                    hdr_d  = 2'b00;
                end
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Gearbox state and registered PHY outputs
    always_ff @(posedge dlx_clk or posedge dlx_reset) begin
        if (dlx_reset) begin
            beat_q    <= 1'b0;
            seq_q     <= 6'd0;
            mode_q    <= M_DATA;
            hdr_q     <= 2'b00;
            data_q    <= {DATA_W{1'b0}};
            seq_out_q <= 6'd0;
            hv_q      <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            mode_q    <= mode_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            seq_out_q <= seq_out_d;
            hv_q      <= hv_d;
            uf_q      <= uf_d;
        end
    end

`ifdef OCX_DLX_TX_GBX_EDPL_EN
    // EDPL parity accumulator, odd-parity toggle and inject tracking
    always_ff @(posedge dlx_clk or posedge dlx_reset) begin
        if (dlx_reset) begin
            par_q      <= 1'b0;
            t_q        <= 1'b0;
            inj_q      <= 1'b0;
            inj_prev_q <= 1'b0;
            hwwe_q     <= 1'b0;
        end else begin
            par_q      <= par_d;
            t_q        <= t_d;
            inj_q      <= inj_d;
            inj_prev_q <= edpl_ena & edpl_inj;
            hwwe_q     <= rise_s;
        end
    end
`endif

    assign dlx_phy_tx_seq       = seq_out_q;
    assign dlx_phy_tx_header    = hdr_q;
    assign dlx_phy_tx_hdr_valid = hv_q;
    assign dlx_phy_tx_data      = data_q;
    assign gb_underrun          = uf_q;

endmodule
